// File: rtl/aes_pkg.sv
// aes_pkg: constants and state type shared by the AES-128 controller, cipher core and key schedule.
package aes_pkg;
    localparam int NUM_ROUNDS = 10;
    localparam logic [2:0] PH_IDLE  = 3'b000;
    localparam logic [2:0] PH_LOAD  = 3'b010;
    localparam logic [2:0] PH_ROUND = 3'b011;
    localparam logic [2:0] PH_DONE  = 3'b100;
    localparam logic [2:0] PH_HOLD  = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_DONE} aes_state_e;
endpackage

// File: rtl/aes_core_ctrl.sv
// aes_core_ctrl: sequences LOAD / ROUND 0..NUM_ROUNDS / DONE for the iterative AES-128 datapath.
// Defining AES_CTRL_ABORT_EN adds abort_in, which returns any busy state to IDLE.
module aes_core_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int CNT_W      = 4,
    parameter int PH_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid_in,
    output logic             start_ready_out,
    input  logic             key_valid_in,
    output logic             key_start_out,
    output logic [CNT_W-1:0] key_round_out,
    output logic [PH_W-1:0]  core_phase_out,
    output logic [CNT_W-1:0] core_count_out,
    output logic             out_valid_out,
    input  logic             out_ready_in,
`ifdef AES_CTRL_ABORT_EN
    input  logic             abort_in,
`endif
    output logic             busy_out
);
    aes_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE:  state_d = start_valid_in ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                state_d = ST_ROUND;
                count_d = '0;
            end
            ST_ROUND: begin
                if (key_valid_in) begin
                    state_d = (count_q == CNT_W'(NUM_ROUNDS)) ? ST_DONE : ST_ROUND;
                    count_d = (count_q == CNT_W'(NUM_ROUNDS)) ? '0 : count_q + 1'b1;
                end
            end
            default:  state_d = out_ready_in ? ST_IDLE : ST_DONE;
        endcase
`ifdef AES_CTRL_ABORT_EN
        if (abort_in && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            count_d = '0;
        end
`endif
    end

    // Only the ROUND phase looks at an input: a missing round key turns it into HOLD.
    always_comb begin
        case (state_q)
            ST_LOAD:  phase = PH_LOAD;
            ST_ROUND: phase = key_valid_in ? PH_ROUND : PH_HOLD;
            ST_DONE:  phase = PH_DONE;
            default:  phase = PH_IDLE;
        endcase
    end

    assign core_phase_out  = PH_W'(phase);
    assign core_count_out  = count_q;
    assign key_round_out   = count_q;
    assign key_start_out   = state_q == ST_LOAD;
    assign out_valid_out   = state_q == ST_DONE;
    assign start_ready_out = state_q == ST_IDLE;
    assign busy_out        = state_q != ST_IDLE;
endmodule

// File: tb/tb_aes_core_ctrl.sv
// tb_aes_core_ctrl: table-driven check of the AES controller sequencing plus reset/abort corner cases.
module tb_aes_core_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_valid_in = 1'b0;
    logic       key_valid_in = 1'b0;
    logic       out_ready_in = 1'b0;
    logic       abort_in = 1'b0;
    logic       start_ready_out, key_start_out, out_valid_out, busy_out;
    logic [3:0] key_round_out, core_count_out;
    logic [2:0] core_phase_out;
    int         total = 0;
    int         bad = 0;

    aes_core_ctrl dut (
        .clk(clk),
        .rst(rst),
        .start_valid_in(start_valid_in),
        .start_ready_out(start_ready_out),
        .key_valid_in(key_valid_in),
        .key_start_out(key_start_out),
        .key_round_out(key_round_out),
        .core_phase_out(core_phase_out),
        .core_count_out(core_count_out),
        .out_valid_out(out_valid_out),
        .out_ready_in(out_ready_in),
`ifdef AES_CTRL_ABORT_EN
        .abort_in(abort_in),
`endif
        .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sv;
        logic       kv;
        logic       ordy;
        logic [2:0] ph;
        logic [3:0] cnt;
        logic       ov;
        logic       ks;
        logic       bz;
        logic       rd;
    } vec_t;

    vec_t tbl[$];

    // packed view: {phase, count, out_valid, key_start, busy, start_ready}; key_round must equal count
    function automatic logic [10:0] obs();
        return {core_phase_out, core_count_out, out_valid_out, key_start_out, busy_out, start_ready_out};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp || key_round_out !== core_count_out) begin
            bad++;
            $display("FAIL %s: got ph=%b cnt=%0d ov=%b ks=%b busy=%b rdy=%b kr=%0d, expected ph=%b cnt=%0d ov=%b ks=%b busy=%b rdy=%b",
                     name, got[10:8], got[7:4], got[3], got[2], got[1], got[0], key_round_out,
                     exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic sv, kv, ordy, input logic [2:0] ph, input logic [3:0] c,
                       input logic ov, ks, bz, rd);
        tbl.push_back('{sv, kv, ordy, ph, c, ov, ks, bz, rd});
    endtask

    task automatic t_idle(input logic sv);
        add(sv, 1'b1, 1'b1, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic t_load(input logic sv, input logic kv);
        add(sv, kv, 1'b1, 3'b010, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic t_round(input logic sv, input logic kv, input logic ordy, input logic [3:0] c);
        add(sv, kv, ordy, kv ? 3'b011 : 3'b101, c, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic t_done(input logic sv, input logic ordy);
        add(sv, 1'b1, ordy, 3'b100, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drive(input logic sv, input logic kv, input logic ordy);
        @(negedge clk);
        start_valid_in = sv;
        key_valid_in = kv;
        out_ready_in = ordy;
        #1;
    endtask

    task automatic run_to_count(input int n);
        drive(1'b1, 1'b0, 1'b0);
        check("accept_idle", obs(), {3'b000, 4'd0, 4'b0001});
        drive(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < n; c++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check("at_count", obs(), {3'b011, 4'(n), 4'b0010});
    endtask

    task automatic no_valid_for(input int n, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            seen |= out_valid_out;
        end
        total++;
        if (seen || !start_ready_out) begin
            bad++;
            $display("FAIL %s: out_valid seen=%b start_ready=%b, expected 0 and 1", name, seen, start_ready_out);
        end
    endtask

    initial begin
        // block A: plain run, key always valid; stray key_valid/out_ready outside their states
        t_idle(1'b1);
        t_load(1'b0, 1'b1);
        for (int c = 0; c <= 10; c++) t_round(1'b0, 1'b1, c == 3, 4'(c));
        t_done(1'b0, 1'b1);
        t_idle(1'b0);
        // block B: 3-cycle key stall at count 4, then 5 cycles of backpressure with start pending
        t_idle(1'b1);
        t_load(1'b0, 1'b0);
        for (int c = 0; c <= 3; c++) t_round(1'b0, 1'b1, 1'b0, 4'(c));
        repeat (3) t_round(1'b0, 1'b0, 1'b1, 4'd4);
        for (int c = 4; c <= 10; c++) t_round(1'b0, 1'b1, 1'b0, 4'(c));
        repeat (5) t_done(1'b1, 1'b0);
        t_done(1'b1, 1'b1);
        t_idle(1'b1);
        // block C: start held high, so the next block is accepted on the first IDLE cycle
        t_load(1'b1, 1'b1);
        for (int c = 0; c <= 10; c++) t_round(1'b1, 1'b1, 1'b0, 4'(c));
        t_done(1'b1, 1'b1);
        t_idle(1'b1);
        t_load(1'b0, 1'b1);

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check("reset_state", obs(), {3'b000, 4'd0, 4'b0001});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].sv, tbl[i].kv, tbl[i].ordy);
            check($sformatf("vec%0d", i), obs(),
                  {tbl[i].ph, tbl[i].cnt, tbl[i].ov, tbl[i].ks, tbl[i].bz, tbl[i].rd});
        end
        drive(1'b0, 1'b1, 1'b0);
        check("tail_round0", obs(), {3'b011, 4'd0, 4'b0010});

        // asynchronous reset in the middle of ROUND at count 5
        drive(1'b0, 1'b1, 1'b0);
        for (int c = 1; c < 5; c++) drive(1'b0, 1'b1, 1'b0);
        check("pre_reset_count5", obs(), {3'b011, 4'd5, 4'b0010});
        rst = 1'b1;
        #1 check("async_reset", obs(), {3'b000, 4'd0, 4'b0001});
        @(negedge clk) rst = 1'b0;
        no_valid_for(16, "after_reset");

`ifdef AES_CTRL_ABORT_EN
        run_to_count(7);
        abort_in = 1'b1;
        @(negedge clk) abort_in = 1'b0;
        #1 check("abort_round", obs(), {3'b000, 4'd0, 4'b0001});
        no_valid_for(14, "after_abort");
        run_to_count(10);
        drive(1'b0, 1'b1, 1'b0);
        check("done_before_abort", obs(), {3'b100, 4'd0, 4'b1010});
        abort_in = 1'b1;
        out_ready_in = 1'b1;
        @(negedge clk) abort_in = 1'b0;
        out_ready_in = 1'b0;
        #1 check("abort_done", obs(), {3'b000, 4'd0, 4'b0001});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_core_ctrl.md
Name: aes_core_ctrl

Overview:
Sequencer for the iterative AES-128 cipher datapath. Accepts a block-start handshake from the host and drives the datapath's 3-bit phase code and 4-bit round index. Stalls rounds when the key schedule has no round key ready, and holds the result until the host accepts it. Sits between the host/bus interface and the cipher core plus key-expansion unit.

Parameters:
NUM_ROUNDS, 10, index of the final round; rounds 0..NUM_ROUNDS are issued
CNT_W, 4, width of the round index
PH_W, 3, width of the datapath phase code

Ports:
clk  in  1  sole clock; all state changes on posedge
rst  in  1  reset
start_valid_in  in  1  host requests a new block; plaintext is stable on the datapath text inputs while high
start_ready_out  out  1  controller can accept; high only in IDLE
key_valid_in  in  1  key schedule presents the round key for key_round_out this cycle
key_start_out  out  1  one-cycle pulse telling the key schedule to restart at round 0
key_round_out  out  CNT_W  round key index requested; equals the datapath round index
core_phase_out  out  PH_W  phase code to the datapath
core_count_out  out  CNT_W  round index to the datapath
out_valid_out  out  1  ciphertext valid on the datapath outputs
out_ready_in  in  1  host accepts the ciphertext
busy_out  out  1  high in every state except IDLE

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- States and phase codes:
  - IDLE: phase 000
  - LOAD: phase 010
  - ROUND: phase 011 when key_valid_in=1, otherwise HOLD code 101
  - DONE: phase 100
- The datapath updates only on phase codes 010 and 011; HOLD (101) freezes it.
- The ROUND phase code is combinational from key_valid_in. No other output depends combinationally on inputs except start_ready_out, which is decoded from state.
- Reset values: state IDLE, round count 0, core_phase_out 000, core_count_out 0, key_round_out 0, key_start_out 0, out_valid_out 0, busy_out 0, start_ready_out 1.
- Reset mid-operation returns to IDLE asynchronously. The in-flight block is discarded and no out_valid_out is produced.
- IDLE -> LOAD on a posedge with start_valid_in && start_ready_out. key_start_out is registered and is high for exactly the LOAD cycle.
- LOAD -> ROUND unconditionally after 1 cycle, with count 0.
- In ROUND:
  - The count increments only on posedges where key_valid_in=1, i.e. when phase 011 was driven.
  - If key_valid_in=1 and count==NUM_ROUNDS, go to DONE and reset count to 0.
  - If key_valid_in=0, state and count hold.
- Count never exceeds NUM_ROUNDS and is 0 outside ROUND.
- In DONE, out_valid_out=1 and holds while out_ready_in=0. On a posedge with out_ready_in=1, go to IDLE.
- A start request arriving during DONE is not accepted until IDLE; start_ready_out is 0 in DONE. A back-to-back block therefore costs one IDLE cycle.
- Latency with key_valid_in tied high: out_valid_out rises 13 cycles after the accepting posedge (1 LOAD cycle, 11 ROUND cycles). Each low cycle of key_valid_in during ROUND adds one cycle.
- key_valid_in is ignored outside ROUND. out_ready_in is ignored outside DONE.

Optional Feature:
AES_CTRL_ABORT_EN.
- Defined: adds input abort_in (1 bit).
  - In LOAD, ROUND or DONE, abort_in=1 forces IDLE at the next posedge and clears count.
  - abort_in has priority over every other transition, including the DONE handshake on the same edge.
  - No out_valid_out is issued after the abort edge.
  - abort_in is ignored in IDLE.
- Undefined: no abort_in port and no abort logic; the block is otherwise identical.

Decomposition:
- Shared package aes_pkg holds:
  - phase-code constants PH_IDLE=000, PH_LOAD=010, PH_ROUND=011, PH_DONE=100, PH_HOLD=101
  - NUM_ROUNDS=10
  - the state enumeration typedef
- The same package is used by the cipher core and the key schedule.
- No sub-module: state register, round counter and output decode live in one module.

Test Plan:
- Reset then idle: hold rst 3 cycles, release -> phase 000, count 0, start_ready_out=1, busy_out=0. Assert rst mid-ROUND at count 5 -> immediate IDLE, no out_valid_out.
- Single block, key_valid_in=1, out_ready_in=1: accept at edge T -> phase 010 at T+1, key_start_out pulse at T+1, phase 011 with counts 0..10 at T+2..T+12, phase 100 and out_valid_out at T+13, IDLE at T+14. Check FIPS-197 vector key 000102..0f, plaintext 00112233..ff -> ciphertext 69c4e0d8..c55a.
- Key stall: drop key_valid_in for 3 cycles at count 4 -> phase 101 for those cycles, count holds at 4, out_valid_out delayed to T+16, ciphertext still correct.
- Output backpressure: out_ready_in=0 for 5 cycles in DONE -> out_valid_out and phase 100 held. start_valid_in=1 during DONE is not accepted; it is accepted one cycle after IDLE is entered.
- Two back-to-back blocks with start_valid_in held high -> second accept occurs on the first IDLE cycle; both ciphertexts are correct and in order.
- With AES_CTRL_ABORT_EN: pulse abort_in at count 7 -> IDLE next edge, no out_valid_out. abort_in and out_ready_in high together in DONE -> IDLE, same as abort.
